// File: rtl/receiver_pkg.sv
// Shared types and elaboration helpers for the BPSK receiver demodulator.
package receiver_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CAL       = 2'd1,
      WAIT_SYNC = 2'd2,
      RECV      = 2'd3
   } state_e;

   localparam int COEF_W     = 2;
   // Room for up to eight 2-bit template coefficients.
   localparam int TEMPLATE_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int acc_width(input int sample_w, input int cal_samples, input int spb);
      return sample_w + 2 + clog2((cal_samples > spb) ? cal_samples : spb);
   endfunction

   function automatic logic [COEF_W-1:0] tmpl_coef(input logic [TEMPLATE_W-1:0] tmpl, input int idx);
      return tmpl[COEF_W*idx +: COEF_W];
   endfunction

endpackage

// File: rtl/receiver_byte_fifo.sv
// Byte FIFO for decoded receiver bytes; a pop frees its slot for a push
// in the same cycle, so push+pop while full is accepted.
module receiver_byte_fifo
   import receiver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       full_o
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CNT_W = clog2(DEPTH + 1);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign data_o  = mem_q[rd_q];

   always_comb begin
      do_pop  = pop_i && valid_o;
      do_push = push_i && (!full_o || do_pop);
      rd_d    = do_pop  ? inc(rd_q) : rd_q;
      wr_d    = do_push ? inc(wr_q) : wr_q;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (do_push) mem_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/receiver_bpsk_demod.sv
// BPSK bit demodulator: preamble phase calibration, per-bit template
// correlation, LSB-first byte assembly into an output FIFO.
//
// state     | meaning
// IDLE      | after reset, waiting for cal_start
// CAL       | accumulating preamble against every template rotation
// WAIT_SYNC | calibrated, waiting for sync_in with a valid sample
// RECV      | correlating bits of a frame
module receiver_bpsk_demod
   import receiver_pkg::*;
#(
   parameter int                    SAMPLE_W        = 8,
   parameter int                    MIDPOINT        = 127,
   parameter int                    CARRIER_P       = 3,
   parameter logic [TEMPLATE_W-1:0] TEMPLATE        = 16'h0034,
   parameter int                    SAMPLES_PER_BIT = 45,
   parameter int                    CAL_SAMPLES     = 45,
   parameter int                    FRAME_BYTES     = 6,
   parameter int                    FIFO_DEPTH      = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          sample_valid,
   input  logic [SAMPLE_W-1:0]           ad,
   input  logic                          cal_start,
   input  logic                          sync_in,
   output logic                          sync_out,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          cal_done,
   output logic [clog2(CARRIER_P)-1:0]   cal_phase,
   output logic                          overflow
);

   localparam int PH_W  = clog2(CARRIER_P);
   localparam int ACC_W = acc_width(SAMPLE_W, CAL_SAMPLES, SAMPLES_PER_BIT);
   localparam int MAX_N = (CAL_SAMPLES > SAMPLES_PER_BIT) ? CAL_SAMPLES : SAMPLES_PER_BIT;
   localparam int CNT_W = clog2(MAX_N + 1);

   state_e                   state_q, state_d;
   logic [PH_W-1:0]          ph_q, ph_d, cal_phase_q, cal_phase_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [ACC_W-1:0]  cal_acc_q [CARRIER_P];
   logic signed [ACC_W-1:0]  cal_acc_d [CARRIER_P];
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base;
   logic                     pend_q, pend_d, cal_done_q, cal_done_d, armed_q, armed_d;
   logic                     overflow_q, overflow_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic [7:0]               byte_q, byte_d, byte_cnt_q, byte_cnt_d, byte_nxt;
   logic                     bit_dec, push, fifo_pop, fifo_full;
   logic signed [SAMPLE_W:0] c;
   logic signed [ACC_W-1:0]  c_ext;
   int                       best;

   assign c     = $signed({1'b0, ad}) - $signed((SAMPLE_W + 1)'(MIDPOINT));
   assign c_ext = {{(ACC_W - SAMPLE_W - 1){c[SAMPLE_W]}}, c};

   // Coefficients are only 0/+1/-1, so the product is a select or negate.
   function automatic logic signed [ACC_W-1:0] term(input logic [PH_W-1:0] ph, input int rot,
                                                    input logic signed [ACC_W-1:0] x);
      int s;
      s = int'(ph) + rot;
      if (s >= CARRIER_P) s = s - CARRIER_P;
      case (tmpl_coef(TEMPLATE, s))
         2'b01:   return x;
         2'b11:   return -x;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      cnt_d       = cnt_q;
      cal_acc_d   = cal_acc_q;
      acc_d       = acc_q;
      acc_base    = acc_q;
      pend_d      = pend_q;
      cal_phase_d = cal_phase_q;
      cal_done_d  = cal_done_q;
      bit_cnt_d   = bit_cnt_q;
      byte_d      = byte_q;
      byte_cnt_d  = byte_cnt_q;
      bit_dec     = !acc_q[ACC_W-1] && (acc_q != '0);
      byte_nxt    = {bit_dec, byte_q[7:1]};
      push        = 1'b0;
      sync_out    = 1'b0;
      best        = 0;

      if (cal_start)
         ph_d = '0;
      else if (sample_valid)
         ph_d = (ph_q == PH_W'(CARRIER_P - 1)) ? '0 : ph_q + PH_W'(1);

      if (cal_start) begin
         state_d    = CAL;
         cal_done_d = 1'b0;
         cnt_d      = '0;
         pend_d     = 1'b0;
         acc_d      = '0;
         bit_cnt_d  = '0;
         byte_d     = '0;
         byte_cnt_d = '0;
         for (int r = 0; r < CARRIER_P; r++) cal_acc_d[r] = '0;
      end else begin
         case (state_q)
            CAL: begin
               if (pend_q) begin
                  for (int r = 1; r < CARRIER_P; r++)
                     if (cal_acc_q[r] > cal_acc_q[best]) best = r;
                  cal_phase_d = PH_W'(best);
                  cal_done_d  = 1'b1;
                  pend_d      = 1'b0;
                  cnt_d       = '0;
                  state_d     = WAIT_SYNC;
               end else if (sample_valid) begin
                  for (int r = 0; r < CARRIER_P; r++)
                     cal_acc_d[r] = cal_acc_q[r] + term(ph_q, r, c_ext);
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(CAL_SAMPLES - 1)) pend_d = 1'b1;
               end
            end
            WAIT_SYNC: begin
               if (sync_in && armed_q && sample_valid) begin
                  state_d    = RECV;
                  acc_d      = term(ph_q, int'(cal_phase_q), c_ext);
                  cnt_d      = CNT_W'(1);
                  pend_d     = 1'b0;
                  bit_cnt_d  = '0;
                  byte_d     = '0;
                  byte_cnt_d = '0;
               end
            end
            RECV: begin
               if (!sync_in) begin
                  state_d    = WAIT_SYNC;
                  acc_d      = '0;
                  cnt_d      = '0;
                  pend_d     = 1'b0;
                  bit_cnt_d  = '0;
                  byte_d     = '0;
                  byte_cnt_d = '0;
               end else begin
                  if (pend_q) begin
                     byte_d    = byte_nxt;
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     acc_base  = '0;
                     pend_d    = 1'b0;
                     if (bit_cnt_q == 3'd7) begin
                        push = 1'b1;
                        if (byte_cnt_q == 8'(FRAME_BYTES - 1)) begin
                           sync_out   = 1'b1;
                           state_d    = WAIT_SYNC;
                           byte_cnt_d = '0;
                        end else begin
                           byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                     end
                  end
                  acc_d = acc_base;
                  // A sample may land in the decision cycle; it starts the next bit.
                  if (sample_valid && state_d == RECV) begin
                     acc_d = acc_base + term(ph_q, int'(cal_phase_q), c_ext);
                     if (cnt_q == CNT_W'(SAMPLES_PER_BIT - 1)) begin
                        cnt_d  = '0;
                        pend_d = 1'b1;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      // A completed frame must see sync_in low before the next one may start.
      if (!sync_in)
         armed_d = 1'b1;
      else if (sync_out)
         armed_d = 1'b0;
      else
         armed_d = armed_q;

      overflow_d = overflow_q | (push & fifo_full & ~fifo_pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ph_q        <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         pend_q      <= 1'b0;
         cal_phase_q <= '0;
         cal_done_q  <= 1'b0;
         armed_q     <= 1'b1;
         overflow_q  <= 1'b0;
         bit_cnt_q   <= '0;
         byte_q      <= '0;
         byte_cnt_q  <= '0;
         for (int r = 0; r < CARRIER_P; r++) cal_acc_q[r] <= '0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         pend_q      <= pend_d;
         cal_phase_q <= cal_phase_d;
         cal_done_q  <= cal_done_d;
         armed_q     <= armed_d;
         overflow_q  <= overflow_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_q      <= byte_d;
         byte_cnt_q  <= byte_cnt_d;
         cal_acc_q   <= cal_acc_d;
      end
   end

   assign fifo_pop  = out_valid && out_ready;
   assign cal_done  = cal_done_q;
   assign cal_phase = cal_phase_q;
   assign overflow  = overflow_q;

   receiver_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock_i     (clock),
      .reset_i     (reset),
      .push_i      (push),
      .push_data_i (byte_nxt),
      .pop_i       (out_ready),
      .data_o      (out_data),
      .valid_o     (out_valid),
      .full_o      (fifo_full)
   );

endmodule

// File: tb/tb_receiver_bpsk_demod.sv
// Directed bench for receiver_bpsk_demod: calibration, frames, backpressure,
// abort, reset and gapped samples, with a byte scoreboard on the output.
module tb_receiver_bpsk_demod;
   import receiver_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] ad = 8'h00;
   logic       cal_start = 1'b0;
   logic       sync_in = 1'b0;
   logic       out_ready = 1'b1;
   logic       sync_out, out_valid, cal_done, overflow;
   logic [7:0] out_data;
   logic [1:0] cal_phase;

   int checks = 0;
   int errors = 0;
   int sync_cnt = 0;
   int tb_ph = 0;
   int rot = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;
   logic [7:0] frame_bytes [6] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hF0, 8'h0F};

   always #5 clock = ~clock;

   receiver_bpsk_demod dut (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (sample_valid),
      .ad           (ad),
      .cal_start    (cal_start),
      .sync_in      (sync_in),
      .sync_out     (sync_out),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .cal_done     (cal_done),
      .cal_phase    (cal_phase),
      .overflow     (overflow)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic b, input int idx);
      case (idx)
         0:       return 8'h7f;
         1:       return b ? 8'h93 : 8'h6d;
         default: return b ? 8'h6d : 8'h93;
      endcase
   endfunction

   task automatic send_sample(input logic b, input int gap);
      ad = pat(b, (tb_ph + rot) % 3);
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      tb_ph = (tb_ph + 1) % 3;
      repeat (gap) step();
   endtask

   task automatic calibrate(input int r);
      rot = r;
      cal_start = 1'b1;
      step();
      cal_start = 1'b0;
      tb_ph = 0;
      chk("cal_done_cleared", cal_done, 0);
      for (int i = 0; i < 45; i++) send_sample(1'b1, 0);
      chk("cal_acc_best", dut.cal_acc_q[r], 570);
      chk("cal_done_early", cal_done, 0);
      step();
      chk("cal_done_set", cal_done, 1);
      chk("cal_phase", cal_phase, r);
   endtask

   task automatic send_frame(input int nbits, input int n_expect, input bit gaps, input bit close);
      logic b;
      sync_in = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         b = frame_bytes[i / 8][i % 8];
         for (int s = 0; s < 45; s++)
            send_sample(b, gaps ? ((s % 4 == 3) ? int'($urandom_range(1, 5)) : 1) : 0);
         if (i % 8 == 7 && i / 8 < n_expect) exp_q.push_back(frame_bytes[i / 8]);
      end
      if (close) begin
         repeat (3) step();
         sync_in = 1'b0;
         repeat (6) step();
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_sync_out", sync_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cal_done", cal_done, 0);
      chk("rst_cal_phase", cal_phase, 0);
      chk("rst_overflow", overflow, 0);
   endtask

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (sync_out === 1'b1) sync_cnt++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL pop_extra observed %0h expected no byte", out_data);
            end
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               checks++;
               assert (out_data === exp_b) else begin
                  errors++;
                  $error("FAIL pop_data observed %0h expected %0h", out_data, exp_b);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk_reset_outputs();
      reset = 1'b0;
      step();
      chk_reset_outputs();

      // Preamble aligned, then rotated by one sample.
      calibrate(0);
      chk("cal_state", dut.state_q, WAIT_SYNC);
      calibrate(1);

      // Full frame with a free-running consumer.
      send_frame(48, 6, 1'b0, 1'b1);
      chk("t3_sync_cnt", sync_cnt, 1);
      chk("t3_overflow", overflow, 0);
      chk("t3_sb_empty", exp_q.size(), 0);

      // Backpressure: only the first four bytes fit.
      out_ready = 1'b0;
      send_frame(48, 4, 1'b0, 1'b1);
      chk("t4_valid", out_valid, 1);
      chk("t4_head", out_data, 8'hFF);
      chk("t4_overflow", overflow, 1);
      chk("t4_sync_cnt", sync_cnt, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) step();
      chk("t4_drained", out_valid, 0);
      chk("t4_sb_empty", exp_q.size(), 0);

      // Abort after 20 bits, then a clean frame.
      send_frame(20, 2, 1'b0, 1'b1);
      chk("t5_state", dut.state_q, WAIT_SYNC);
      chk("t5_sync_cnt", sync_cnt, 2);
      chk("t5_sb_empty", exp_q.size(), 0);
      send_frame(48, 6, 1'b0, 1'b1);
      chk("t5b_sync_cnt", sync_cnt, 3);
      chk("t5b_sb_empty", exp_q.size(), 0);

      // Reset mid-frame, then a gapped frame after recalibration.
      send_frame(12, 1, 1'b0, 1'b0);
      chk("t6_in_recv", dut.state_q, RECV);
      reset = 1'b1;
      sync_in = 1'b0;
      step();
      chk_reset_outputs();
      chk("t6_sb_empty", exp_q.size(), 0);
      reset = 1'b0;
      tb_ph = 0;
      step();
      calibrate(0);
      send_frame(48, 6, 1'b1, 1'b1);
      chk("t6_sync_cnt", sync_cnt, 4);
      chk("t6_overflow", overflow, 0);
      chk("t6_sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
